// File: rtl/para_seri_pkg.sv
// Shared constants and helpers for the I2S transmitter.
// Mode encodings, frame width and counter sizing.
package para_seri_pkg;

  localparam int MODE_LJ  = 0;
  localparam int MODE_I2S = 1;

  function automatic int frame_w(input int slot_w);
    return 2 * slot_w;
  endfunction

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    if (r == 0) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/para_seri_i2s_clk_div.sv
// BCLK generator: clock-enable divider, no derived clocks.
// fall_en marks the CLK cycle before each BCLK falling edge.
module i2s_clk_div
  import para_seri_pkg::*;
#(
  parameter int BCLK_DIV = 8
) (
  input  logic CLK,
  input  logic RST,
  output logic BCLK,
  output logic fall_en
);

  localparam int DW = clog2(BCLK_DIV);
  localparam logic [DW-1:0] LAST = DW'(BCLK_DIV - 1);
  localparam logic [DW-1:0] HALF = DW'(BCLK_DIV / 2);

  logic [DW-1:0] div_cnt;
  logic [DW-1:0] div_nxt;

  // Wrap the divider and flag its last phase.
  always_comb begin
    fall_en = (div_cnt == LAST);
    div_nxt = fall_en ? '0 : div_cnt + DW'(1);
  end

  // BCLK tracks the registered counter: high in its upper half.
  always_ff @(posedge CLK) begin
    if (RST) begin
      div_cnt <= '0;
      BCLK    <= 1'b0;
    end else begin
      div_cnt <= div_nxt;
      BCLK    <= (div_nxt >= HALF);
    end
  end

endmodule

// File: rtl/para_seri_i2s.sv
// Stereo PCM to I2S / left-justified serialiser with one-sample buffer.
// Define PARA_SERI_UNDERRUN_CNT_EN to add the UNDERRUN_CNT output.
module para_seri_i2s
  import para_seri_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int SLOT_W   = 16,
  parameter int BCLK_DIV = 8,
  parameter int I2S_MODE = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              EN,
  input  logic              S_VALID,
  output logic              S_READY,
  input  logic [DATA_W-1:0] S_LEFT,
  input  logic [DATA_W-1:0] S_RIGHT,
  output logic              BCLK,
  output logic              LRCLK,
  output logic              SDOUT,
  output logic              FRAME_START,
  output logic              UNDERRUN
`ifdef PARA_SERI_UNDERRUN_CNT_EN
  ,
  output logic [15:0]       UNDERRUN_CNT
`endif
);

  localparam int FW = frame_w(SLOT_W);
  localparam int BW = clog2(FW);
  localparam logic [BW-1:0] LAST_BIT = BW'(FW - 1);
  localparam logic [BW-1:0] SLOT_B   = BW'(SLOT_W);

  logic              fall_en;
  logic [BW-1:0]     bit_cnt;
  logic [BW-1:0]     bit_nxt;
  logic              buf_full;
  logic              buf_full_nxt;
  logic [DATA_W-1:0] buf_l;
  logic [DATA_W-1:0] buf_r;
  logic [DATA_W-1:0] src_l;
  logic [DATA_W-1:0] src_r;
  logic [FW-1:0]     shifter;
  logic [FW-1:0]     frame_new;
  logic              dly;
  logic              cur_bit;
  logic              load;
  logic              take;
  logic              use_buf;
  logic              use_byp;
  logic              starve;

  i2s_clk_div #(
    .BCLK_DIV(BCLK_DIV)
  ) u_div (
    .CLK    (CLK),
    .RST    (RST),
    .BCLK   (BCLK),
    .fall_en(fall_en)
  );

  // Frame-load decision and the next bit of the stream.
  always_comb begin
    bit_nxt = (bit_cnt == LAST_BIT) ? '0 : bit_cnt + BW'(1);
    load    = fall_en && (bit_cnt == LAST_BIT);
    take    = S_VALID && S_READY;
    use_buf = load && EN && buf_full;
    use_byp = load && EN && !buf_full && take;
    starve  = load && EN && !buf_full && !take;
    src_l   = buf_full ? buf_l : S_LEFT;
    src_r   = buf_full ? buf_r : S_RIGHT;
    frame_new = '0;
    if (use_buf || use_byp) begin
      frame_new[FW-1 -: DATA_W]     = src_l;
      frame_new[SLOT_W-1 -: DATA_W] = src_r;
    end
    cur_bit = load ? frame_new[FW-1] : shifter[FW-1];
    buf_full_nxt = buf_full;
    if (use_buf) buf_full_nxt = 1'b0;
    else if (take && !use_byp) buf_full_nxt = 1'b1;
  end

  // Handshake buffer, frame counters, shifter and serial output.
  always_ff @(posedge CLK) begin
    if (RST) begin
      bit_cnt     <= LAST_BIT;
      LRCLK       <= 1'b0;
      SDOUT       <= 1'b0;
      S_READY     <= 1'b0;
      FRAME_START <= 1'b0;
      UNDERRUN    <= 1'b0;
      buf_full    <= 1'b0;
      buf_l       <= '0;
      buf_r       <= '0;
      shifter     <= '0;
      dly         <= 1'b0;
    end else begin
      buf_full    <= buf_full_nxt;
      S_READY     <= !buf_full_nxt;
      FRAME_START <= load;
      UNDERRUN    <= starve;
      if (take && !use_byp) begin
        buf_l <= S_LEFT;
        buf_r <= S_RIGHT;
      end
      if (fall_en) begin
        bit_cnt <= bit_nxt;
        LRCLK   <= (bit_nxt >= SLOT_B);
        shifter <= load ? {frame_new[FW-2:0], 1'b0}
                        : {shifter[FW-2:0], 1'b0};
        dly     <= cur_bit;
        SDOUT   <= (I2S_MODE == MODE_I2S) ? dly : cur_bit;
      end
    end
  end

`ifdef PARA_SERI_UNDERRUN_CNT_EN
  // Saturating tally of starved frame loads.
  always_ff @(posedge CLK) begin
    if (RST) UNDERRUN_CNT <= '0;
    else if (starve && UNDERRUN_CNT != 16'hFFFF)
      UNDERRUN_CNT <= UNDERRUN_CNT + 16'd1;
  end
`endif

endmodule

// File: tb/tb_para_seri_i2s.sv
// Bench: two transmitters (I2S 16/16 and LJ 12-in-16) fed one stream,
// checked cycle by cycle against a frame-level reference model.
module tb_para_seri_i2s;

  localparam int DIV  = 8;
  localparam int SLOT = 16;
  localparam int FW   = 32;
  localparam int DW0  = 16;
  localparam int DW1  = 12;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        EN = 1'b1;
  logic        S_VALID = 1'b0;
  logic [15:0] S_LEFT = '0;
  logic [15:0] S_RIGHT = '0;

  logic bclk0, lr0, sd0, fs0, ur0, rdy0;
  logic bclk1, lr1, sd1, fs1, ur1, rdy1;
`ifdef PARA_SERI_UNDERRUN_CNT_EN
  logic [15:0] ucnt0, ucnt1;
`endif

  para_seri_i2s #(
    .DATA_W(DW0), .SLOT_W(SLOT), .BCLK_DIV(DIV), .I2S_MODE(1)
  ) dut0 (
`ifdef PARA_SERI_UNDERRUN_CNT_EN
    .UNDERRUN_CNT(ucnt0),
`endif
    .CLK(CLK), .RST(RST), .EN(EN),
    .S_VALID(S_VALID), .S_READY(rdy0),
    .S_LEFT(S_LEFT), .S_RIGHT(S_RIGHT),
    .BCLK(bclk0), .LRCLK(lr0), .SDOUT(sd0),
    .FRAME_START(fs0), .UNDERRUN(ur0)
  );

  para_seri_i2s #(
    .DATA_W(DW1), .SLOT_W(SLOT), .BCLK_DIV(DIV), .I2S_MODE(0)
  ) dut1 (
`ifdef PARA_SERI_UNDERRUN_CNT_EN
    .UNDERRUN_CNT(ucnt1),
`endif
    .CLK(CLK), .RST(RST), .EN(EN),
    .S_VALID(S_VALID), .S_READY(rdy1),
    .S_LEFT(S_LEFT[15:4]), .S_RIGHT(S_RIGHT[15:4]),
    .BCLK(bclk1), .LRCLK(lr1), .SDOUT(sd1),
    .FRAME_START(fs1), .UNDERRUN(ur1)
  );

  always #5 CLK = ~CLK;

  int vectors = 0;
  int miscompares = 0;

  // reference model state
  int          e = 0;
  bit          mbuf_full = 0;
  logic [15:0] mbl = '0, mbr = '0;
  logic [15:0] cl = '0, cr = '0;
  logic        prev = 1'b0;
  logic        exp_rdy = 0, exp_bclk = 0, exp_lr = 0;
  logic        exp_sd0 = 0, exp_sd1 = 0, exp_fs = 0, exp_ur = 0;
  bit          last_take = 0;
  int          ucnt = 0;
  int          pol = 0;
  logic [31:0] cap0 = '0, cap1 = '0;
  logic [31:0] dq[$];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // bit k of a frame: slot sample MSB-first, zero beyond dw bits
  function automatic logic sbit(input int k, input logic [15:0] l,
                                input logic [15:0] r, input int dw);
    int pos;
    logic [15:0] smp;
    pos = k % SLOT;
    smp = (k < SLOT) ? l : r;
    if (pos >= dw) return 1'b0;
    return smp[15-pos];
  endfunction

  task automatic new_sample();
    logic [31:0] w;
    if (dq.size() > 0) w = dq.pop_front();
    else w = $urandom;
    S_LEFT  = w[31:16];
    S_RIGHT = w[15:0];
  endtask

  task automatic drive();
    int nx;
    case (pol)
      1: begin
        if (!S_VALID || last_take) begin
          new_sample();
          S_VALID = 1'b1;
        end
      end
      2: begin
        nx = e + 1;
        if (nx % DIV == 0 && ((nx / DIV - 1) % FW) == 0) begin
          new_sample();
          S_VALID = 1'b1;
        end else S_VALID = 1'b0;
      end
      default: S_VALID = 1'b0;
    endcase
  endtask

  task automatic step();
    bit fall, take, byp, ien;
    int k;
    logic [15:0] il, ir;
    il = S_LEFT; ir = S_RIGHT; ien = EN;
    take = S_VALID && exp_rdy;
    @(posedge CLK);
    fall = 0;
    k = -1;
    if (RST) begin
      e = 0; mbuf_full = 0; cl = '0; cr = '0; prev = 1'b0;
      exp_rdy = 0; exp_lr = 0; exp_sd0 = 0; exp_sd1 = 0;
      exp_fs = 0; exp_ur = 0; last_take = 0; ucnt = 0;
    end else begin
      e++;
      exp_fs = 0; exp_ur = 0; byp = 0;
      fall = (e % DIV) == 0;
      if (fall) k = (e / DIV - 1) % FW;
      if (k == 0) begin
        prev = sbit(FW - 1, cl, cr, DW0);
        exp_fs = 1;
        if (ien && mbuf_full) begin
          cl = mbl; cr = mbr; mbuf_full = 0;
        end else if (ien && take) begin
          cl = il; cr = ir; byp = 1;
        end else begin
          cl = '0; cr = '0;
          if (ien) begin
            exp_ur = 1;
            if (ucnt < 65535) ucnt++;
          end
        end
      end
      if (take && !byp) begin
        mbl = il; mbr = ir; mbuf_full = 1;
      end
      last_take = take;
      exp_rdy = !mbuf_full;
      if (fall) begin
        exp_lr  = (k >= SLOT);
        exp_sd1 = sbit(k, cl, cr, DW1);
        exp_sd0 = (k == 0) ? prev : sbit(k - 1, cl, cr, DW0);
      end
    end
    exp_bclk = ((e % DIV) >= DIV / 2);
    #1;
    chk("d0.BCLK", bclk0, exp_bclk);
    chk("d1.BCLK", bclk1, exp_bclk);
    chk("d0.LRCLK", lr0, exp_lr);
    chk("d1.LRCLK", lr1, exp_lr);
    chk("d0.SDOUT", sd0, exp_sd0);
    chk("d1.SDOUT", sd1, exp_sd1);
    chk("d0.FRAME_START", fs0, exp_fs);
    chk("d1.FRAME_START", fs1, exp_fs);
    chk("d0.UNDERRUN", ur0, exp_ur);
    chk("d1.UNDERRUN", ur1, exp_ur);
    chk("d0.S_READY", rdy0, exp_rdy);
    chk("d1.S_READY", rdy1, exp_rdy);
`ifdef PARA_SERI_UNDERRUN_CNT_EN
    chk("d0.UNDERRUN_CNT", ucnt0, ucnt);
    chk("d1.UNDERRUN_CNT", ucnt1, ucnt);
`endif
    if (fall) begin
      cap0 = {cap0[30:0], sd0};
      cap1 = {cap1[30:0], sd1};
    end
    drive();
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  initial begin
    dq.push_back(32'hA5C3_0F01);
    dq.push_back(32'hA5C3_0F01);
    RST = 1'b1; EN = 1'b1; pol = 0;
    run(3);
    RST = 1'b0; pol = 1;
    run(FW * DIV);
    chk("frame0.i2s", cap0, 32'h52E1_8780);
    chk("frame0.lj", cap1, 32'hA5C0_0F00);
    run(2 * FW * DIV);
    pol = 0;
    run(4 * FW * DIV);
    pol = 2;
    run(FW * DIV);
    pol = 1;
    run(2 * FW * DIV);
    EN = 1'b0; pol = 0;
    run(2 * FW * DIV);
    EN = 1'b1;
    run(FW * DIV);
    pol = 1;
    run(FW * DIV + 100);
    RST = 1'b1;
    run(2);
    RST = 1'b0;
    run(2 * FW * DIV);
    for (int i = 0; i < 24; i++) begin
      pol = $urandom_range(0, 2);
      EN = ($urandom_range(0, 3) != 0);
      run($urandom_range(20, 200));
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
